// File: rtl/frame_validator_if.sv
// Consumer-side byte stream of the frame validator (FIFO head + handshake).
// Latency: none, wires only.
// Backpressure: consumer holds rx_ready low to stall; the source keeps rx_data stable.
//
// Signals:
//   rx_data  : FIFO head byte, meaningful while rx_valid=1
//   rx_valid : head entry present
//   rx_ready : consumer takes the head byte when rx_valid & rx_ready
interface frame_validator_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/frame_validator.sv
// Checks framing and odd parity of captured serial frames; good bytes go into a show-ahead FIFO.
// Latency: 3 edges from confirm_send_data sampled high to rx_valid rising (FIFO empty).
// Backpressure: rx_ready low stalls the FIFO; a good byte arriving while full is dropped and flags overflow.
//
// Ports:
//   control_clock, reset_n     : clock (rising edge), async active-low reset
//   confirm_send_data          : frame-complete level from the shift register
//   parallel_data_buffer       : received byte
//   comm_init_bits             : [1] stop bit (expect 1), [0] start bit (expect 0)
//   parity_check_bit           : received odd-parity bit
//   rx (master)                : FIFO head byte / valid / ready
//   fifo_count                 : occupancy 0..FIFO_DEPTH
//   frame_accepted             : pulse in the cycle a good byte is written
//   overflow                   : sticky, a good byte was lost to a full FIFO
//   parity/framing_error_count : saturating error counters
//   clear_errors               : synchronous clear of counters and overflow
module frame_validator #(
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   control_clock,
  input  logic                   reset_n,
  input  logic                   confirm_send_data,
  input  logic [7:0]             parallel_data_buffer,
  input  logic [1:0]             comm_init_bits,
  input  logic                   parity_check_bit,
  input  logic                   clear_errors,
  frame_validator_if.master      rx,
  output logic [COUNT_WIDTH-1:0] fifo_count,
  output logic                   frame_accepted,
  output logic                   overflow,
  output logic [7:0]             parity_error_count,
  output logic [7:0]             framing_error_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             perr_q, perr_d;
  logic [7:0]             ferr_q, ferr_d;

  logic framing_fail, parity_fail, push_req, push, pop, full, ovf_event;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge control_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // HOLD waits for confirm to drop so a long confirm level yields one frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (confirm_send_data) state_d = SETTLE;
      SETTLE:  state_d = CHECK;
      CHECK:   state_d = HOLD;
      HOLD:    if (!confirm_send_data) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / frame checks ----------------
  // Framing failure masks the parity check so each bad frame is counted once.
  always_comb begin
    framing_fail = 1'b0;
    parity_fail  = 1'b0;
    push_req     = 1'b0;
    if (state_q == CHECK) begin
      framing_fail = (comm_init_bits != 2'b10);
      parity_fail  = !framing_fail && !(^{parallel_data_buffer, parity_check_bit});
      push_req     = !framing_fail && !parity_fail;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop       = rx.rx_valid && rx.rx_ready;
  assign full      = (count_q == COUNT_WIDTH'(FIFO_DEPTH));
  assign push      = push_req && (!full || pop);
  assign ovf_event = push_req && full && !pop;

  // ---------------- FIFO ----------------
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge control_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= parallel_data_buffer;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------- error counters / overflow ----------------
  // clear_errors takes priority over a same-cycle event.
  always_comb begin
    overflow_d = overflow_q | ovf_event;
    perr_d     = (parity_fail  && perr_q != 8'hFF) ? perr_q + 8'd1 : perr_q;
    ferr_d     = (framing_fail && ferr_q != 8'hFF) ? ferr_q + 8'd1 : ferr_q;
    if (clear_errors) begin
      overflow_d = 1'b0;
      perr_d     = 8'h00;
      ferr_d     = 8'h00;
    end
  end

  always_ff @(posedge control_clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      perr_q     <= 8'h00;
      ferr_q     <= 8'h00;
    end else begin
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx.rx_data          = mem_q[rd_ptr_q];
  assign rx.rx_valid         = (count_q != '0);
  assign fifo_count          = count_q;
  assign frame_accepted      = push;
  assign overflow            = overflow_q;
  assign parity_error_count  = perr_q;
  assign framing_error_count = ferr_q;

endmodule

// File: doc/frame_validator.md
Name: frame_validator

Overview:
- Downstream stage of the 11-bit serial-frame shift register, clocked by the same control_clock.
- On each frame-complete indication it captures the data byte, parity bit and start/stop bits, and checks framing and odd parity.
- Good bytes go into a small show-ahead FIFO with a valid/ready consumer handshake; bad frames are dropped and counted in saturating error counters.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- COUNT_WIDTH, 3, width of fifo_count; must equal log2(FIFO_DEPTH)+1.

Ports:
- control_clock  input  1  system/frame clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- confirm_send_data  input  1  frame-complete level from the shift register; may stay high several cycles.
- parallel_data_buffer  input  8  received data byte.
- comm_init_bits  input  2  [1] = stop bit (must be 1), [0] = start bit (must be 0).
- parity_check_bit  input  1  received parity bit (odd parity over the byte).
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  high while the FIFO is not empty.
- rx_ready  input  1  consumer accepts the head byte when rx_valid & rx_ready.
- fifo_count  output  COUNT_WIDTH  current occupancy, 0..FIFO_DEPTH.
- frame_accepted  output  1  one-cycle pulse when a good byte is written to the FIFO.
- overflow  output  1  sticky; a good byte was lost because the FIFO was full.
- parity_error_count  output  8  saturating count of parity-failed frames.
- framing_error_count  output  8  saturating count of start/stop-failed frames.
- clear_errors  input  1  synchronous clear of both counters and overflow.

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE; FIFO empty; rx_valid=0; rx_data=0; fifo_count=0; frame_accepted=0; overflow=0; both counters=0. Reset mid-frame discards any pending capture.
- FSM states: IDLE, SETTLE, CHECK, HOLD.
- IDLE: confirm_send_data=1 sampled -> SETTLE.
- SETTLE: one wait cycle so the shift-register outputs (loaded on the falling edge) are stable.
- CHECK: sample parallel_data_buffer, comm_init_bits, parity_check_bit and evaluate all checks in this cycle. Next state is HOLD.
- HOLD: remain until confirm_send_data=0, then -> IDLE. One frame is processed per confirm assertion regardless of its length.
- If confirm_send_data drops during SETTLE, the frame is still checked in CHECK.
- Framing check: fail if comm_init_bits != 2'b10.
- Parity check: fail if the XOR of the 8 data bits and parity_check_bit is 0.
- Precedence: a framing failure increments framing_error_count only; parity is not evaluated. A parity failure increments parity_error_count. Either failure drops the byte.
- Good frame: push the byte in the CHECK cycle; frame_accepted=1 for that cycle only. Latency is 3 cycles from confirm_send_data sampled high to rx_valid rising (IDLE→SETTLE→CHECK, visible on the next edge) when the FIFO is empty.
- FIFO pop: head advances when rx_valid & rx_ready.
- Simultaneous push and pop, not full: fifo_count unchanged.
- Simultaneous push and pop when full: both succeed, no overflow.
- Push when full with no pop: byte dropped, overflow set, frame_accepted stays 0, fifo_count stays FIFO_DEPTH.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.
- rx_data always reflects the head entry; it is unchanged while rx_valid=1 and rx_ready=0.
- Counters saturate at 255 and do not wrap.
- clear_errors=1: counters and overflow go to 0 on the next edge. If an error or overflow event occurs in the same cycle, clear wins and the event is lost. clear_errors does not affect the FIFO.

Test Plan:
- Good frame: data=0x5A, parity=1, comm_init_bits=2'b10, confirm high 2 cycles, rx_ready=0 -> after 3 cycles rx_valid=1, rx_data=0x5A, fifo_count=1, one frame_accepted pulse; confirm held 5 cycles still yields exactly one push.
- Parity error: data=0x5A, parity=0 -> parity_error_count=1, FIFO empty, frame_accepted never asserted. Then data=0x01, parity=0 -> accepted.
- Framing error: comm_init_bits=2'b00 with a bad parity too -> framing_error_count=1, parity_error_count=0, byte dropped.
- Full/overflow: rx_ready=0, five good frames 0x11..0x55 -> fifo_count=4, overflow=1. Drain with rx_ready=1 -> reads 0x11,0x22,0x33,0x44. Push on a full FIFO in the same cycle as a pop -> no overflow, count stays 4.
- Saturation/clear: 260 parity-bad frames -> parity_error_count=255. Pulse clear_errors in the same cycle as another error -> count=0, overflow=0, FIFO contents unchanged.
- Reset mid-operation: assert reset_n=0 during SETTLE with 2 bytes queued -> immediately rx_valid=0, fifo_count=0, counters=0. After release, a pending-high confirm_send_data is processed as a new frame.
